// File: rtl/vga_pkg.sv
// Shared types and default 640x480@60 timing constants for the video timing path.
package vga_pkg;

    typedef logic [9:0] coord_t;

    localparam int H_VISIBLE_DEF = 640;
    localparam int H_FRONT_DEF   = 16;
    localparam int H_SYNC_DEF    = 96;
    localparam int H_BACK_DEF    = 48;
    localparam int H_TOTAL_DEF   = H_VISIBLE_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;

    localparam int V_VISIBLE_DEF = 480;
    localparam int V_FRONT_DEF   = 10;
    localparam int V_SYNC_DEF    = 2;
    localparam int V_BACK_DEF    = 33;
    localparam int V_TOTAL_DEF   = V_VISIBLE_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;

    // Sync pulses sit right after the front porch; end is inclusive.
    function automatic int sync_start(int visible, int front);
        return visible + front;
    endfunction

    function automatic int sync_end(int visible, int front, int width);
        return visible + front + width - 1;
    endfunction

    localparam int H_SYNC_START_DEF = sync_start(H_VISIBLE_DEF, H_FRONT_DEF);
    localparam int H_SYNC_END_DEF   = sync_end(H_VISIBLE_DEF, H_FRONT_DEF, H_SYNC_DEF);
    localparam int V_SYNC_START_DEF = sync_start(V_VISIBLE_DEF, V_FRONT_DEF);
    localparam int V_SYNC_END_DEF   = sync_end(V_VISIBLE_DEF, V_FRONT_DEF, V_SYNC_DEF);

endpackage

// File: rtl/vga_timing_gen_if.sv
// Position update channel between game logic (master) and the timing generator (slave).
interface vga_timing_gen_if;
    import vga_pkg::*;

    // pos_valid is a one-cycle strobe with no ready: every beat is accepted, the
    // last beat before vblank_start wins, and pos_x/pos_y change only after vblank_start.
    logic   pos_valid;
    coord_t pos_x_in;
    coord_t pos_y_in;
    coord_t pos_x;
    coord_t pos_y;

    modport master (output pos_valid, pos_x_in, pos_y_in, input pos_x, pos_y);
    modport slave  (input pos_valid, pos_x_in, pos_y_in, output pos_x, pos_y);

endinterface

// File: rtl/vga_timing_gen_sync_delay_line.sv
// Width-3 shift register that lines hs/vs/blank up with the renderers' registered colour.
module sync_delay_line #(
    parameter int         DEPTH   = 1,
    parameter logic [2:0] CLR_VAL = 3'b000
) (
    input  logic       vga_clk,
    input  logic       reset_n,
    input  logic [2:0] d,
    output logic [2:0] q
);

    if (DEPTH == 0) begin : g_bypass
        assign q = d;
    end else begin : g_shift
        logic [2:0] stage [DEPTH];

        always_ff @(posedge vga_clk) begin
            if (!reset_n) begin
                for (int i = 0; i < DEPTH; i++) stage[i] <= CLR_VAL;
            end else begin
                stage[0] <= d;
                for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
            end
        end

        assign q = stage[DEPTH-1];
    end

endmodule

// File: rtl/vga_timing_gen.sv
// Video timing master: pixel counters, syncs, frame pulses and tear-free position commit.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_VISIBLE  = H_VISIBLE_DEF,
    parameter int H_FRONT    = H_FRONT_DEF,
    parameter int H_SYNC     = H_SYNC_DEF,
    parameter int H_BACK     = H_BACK_DEF,
    parameter int V_VISIBLE  = V_VISIBLE_DEF,
    parameter int V_FRONT    = V_FRONT_DEF,
    parameter int V_SYNC     = V_SYNC_DEF,
    parameter int V_BACK     = V_BACK_DEF,
    parameter bit SYNC_POL   = 1'b0,
    parameter int PIPE_DELAY = 1,
    parameter int POS_X_RST  = 320,
    parameter int POS_Y_RST  = 240
) (
    input  logic               vga_clk,
    input  logic               reset_n,
    output coord_t             DrawX,
    output coord_t             DrawY,
    output logic               blank,
    output logic               hs,
    output logic               vs,
    output logic               hs_d,
    output logic               vs_d,
    output logic               blank_d,
    output logic               frame_start,
    output logic               vblank_start,
    output logic [15:0]        frame_count,
    vga_timing_gen_if.slave    pos_if
);

    localparam int     H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int     V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam coord_t H_LAST   = coord_t'(H_TOTAL - 1);
    localparam coord_t V_LAST   = coord_t'(V_TOTAL - 1);
    localparam coord_t H_VIS_C  = coord_t'(H_VISIBLE);
    localparam coord_t V_VIS_C  = coord_t'(V_VISIBLE);
    localparam coord_t HS_START = coord_t'(sync_start(H_VISIBLE, H_FRONT));
    localparam coord_t HS_END   = coord_t'(sync_end(H_VISIBLE, H_FRONT, H_SYNC));
    localparam coord_t VS_START = coord_t'(sync_start(V_VISIBLE, V_FRONT));
    localparam coord_t VS_END   = coord_t'(sync_end(V_VISIBLE, V_FRONT, V_SYNC));

    logic        run_q;
    coord_t      hc_q;
    coord_t      vc_q;
    logic [15:0] fcnt_q;
    logic        line_end;
    logic        frame_end;
    logic        hs_act;
    logic        vs_act;

    assign line_end  = (hc_q == H_LAST);
    assign frame_end = line_end && (vc_q == V_LAST);

    // run_q holds the counters at (0,0) for the release edge so the first
    // post-reset cycle shows the frame origin with all outputs enabled.
    always_ff @(posedge vga_clk) begin
        if (!reset_n) begin
            run_q  <= 1'b0;
            hc_q   <= '0;
            vc_q   <= '0;
            fcnt_q <= '0;
        end else begin
            run_q <= 1'b1;
            if (run_q) begin
                if (line_end) begin
                    hc_q <= '0;
                    vc_q <= (vc_q == V_LAST) ? coord_t'(0) : vc_q + coord_t'(1);
                end else begin
                    hc_q <= hc_q + coord_t'(1);
                end
                if (frame_end) fcnt_q <= fcnt_q + 16'd1;
            end
        end
    end

    assign hs_act       = run_q && (hc_q >= HS_START) && (hc_q <= HS_END);
    assign vs_act       = run_q && (vc_q >= VS_START) && (vc_q <= VS_END);
    assign hs           = hs_act ? SYNC_POL : ~SYNC_POL;
    assign vs           = vs_act ? SYNC_POL : ~SYNC_POL;
    assign blank        = run_q && (hc_q < H_VIS_C) && (vc_q < V_VIS_C);
    assign frame_start  = run_q && (hc_q == '0) && (vc_q == '0);
    assign vblank_start = run_q && (hc_q == '0) && (vc_q == V_VIS_C);
    assign DrawX        = hc_q;
    assign DrawY        = vc_q;
    assign frame_count  = fcnt_q;

    coord_t pend_x_q;
    coord_t pend_y_q;
    logic   pend_q;
    coord_t pos_x_q;
    coord_t pos_y_q;

    // A strobe landing on vblank_start itself is newer than anything pending.
    always_ff @(posedge vga_clk) begin
        if (!reset_n) begin
            pos_x_q  <= coord_t'(POS_X_RST);
            pos_y_q  <= coord_t'(POS_Y_RST);
            pend_x_q <= '0;
            pend_y_q <= '0;
            pend_q   <= 1'b0;
        end else if (vblank_start) begin
            if (pos_if.pos_valid) begin
                pos_x_q <= pos_if.pos_x_in;
                pos_y_q <= pos_if.pos_y_in;
            end else if (pend_q) begin
                pos_x_q <= pend_x_q;
                pos_y_q <= pend_y_q;
            end
            pend_q <= 1'b0;
        end else if (pos_if.pos_valid) begin
            pend_x_q <= pos_if.pos_x_in;
            pend_y_q <= pos_if.pos_y_in;
            pend_q   <= 1'b1;
        end
    end

    assign pos_if.pos_x = pos_x_q;
    assign pos_if.pos_y = pos_y_q;

    sync_delay_line #(
        .DEPTH   (PIPE_DELAY),
        .CLR_VAL ({~SYNC_POL, ~SYNC_POL, 1'b0})
    ) u_delay (
        .vga_clk (vga_clk),
        .reset_n (reset_n),
        .d       ({hs, vs, blank}),
        .q       ({hs_d, vs_d, blank_d})
    );

endmodule
